// File: rtl/opra_msg_block_packer.sv
// Stage-1 OPRA packer: left-aligns framed 64-bit messages into 264-bit slots
// and emits blocks of up to three messages with a one-cycle message_en_out pulse.
module opra_msg_block_packer #(
    parameter int MSG_BYTES    = 33,
    parameter int FLUSH_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic                   in_sop,
    input  logic                   in_eop,
    input  logic [2:0]             in_bytes,
    input  logic [63:0]            in_data,
    input  logic                   in_flush,
    output logic [8*MSG_BYTES-1:0] original_data_1,
    output logic [8*MSG_BYTES-1:0] original_data_2,
    output logic [8*MSG_BYTES-1:0] original_data_3,
    output logic                   message_en_out,
    output logic [1:0]             message_number_out,
    output logic                   err_trunc,
    output logic                   err_frame
);
    localparam int SLOT_W = 8 * MSG_BYTES;
    localparam int BP_W   = $clog2(MSG_BYTES + 1);

    typedef enum logic {IDLE, BODY} state_t;

    state_t            state_q, state_d;
    logic [1:0]        fill_q, fill_d;
    logic [BP_W-1:0]   bytepos_q, bytepos_d;
    logic [7:0]        idle_cnt_q, idle_cnt_d;
    logic              flush_pend_q, flush_pend_d;
    logic              trunc_q, trunc_d;
    logic [SLOT_W-1:0] slot_q [3];
    logic [SLOT_W-1:0] slot_d [3];
    logic [SLOT_W-1:0] out_q [3];
    logic [SLOT_W-1:0] out_d [3];
    logic              men_q, men_d;
    logic [1:0]        num_q, num_d;
    logic              etr_q, etr_d;
    logic              efr_q, efr_d;

    logic              accept, commit, over, trunc_prev, counting, flush_req, emit;
    logic [BP_W-1:0]   base;
    logic [3:0]        nb;
    logic [2:0]        count_post;
    logic [SLOT_W-1:0] placed;

    // Zero the bytes of an eop word beyond its valid count.
    function automatic logic [63:0] keep_bytes(input logic [63:0] d, input logic [3:0] n);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            if (k < int'(n)) r[63-8*k -: 8] = d[63-8*k -: 8];
        end
        return r;
    endfunction

    always_comb begin
        state_d      = state_q;
        fill_d       = fill_q;
        bytepos_d    = bytepos_q;
        idle_cnt_d   = idle_cnt_q;
        flush_pend_d = flush_pend_q;
        trunc_d      = trunc_q;
        slot_d       = slot_q;
        out_d        = out_q;
        men_d        = 1'b0;
        num_d        = num_q;
        etr_d        = 1'b0;
        efr_d        = 1'b0;
        accept       = 1'b0;
        commit       = 1'b0;
        over         = 1'b0;
        trunc_prev   = 1'b0;
        base         = '0;
        nb           = (in_eop && in_bytes != 3'd0) ? {1'b0, in_bytes} : 4'd8;
        placed       = '0;

        if (in_valid) begin
            if (in_sop) begin
                efr_d  = (state_q == BODY);
                accept = 1'b1;
            end else if (state_q == BODY) begin
                accept     = 1'b1;
                base       = bytepos_q;
                trunc_prev = trunc_q;
            end else begin
                efr_d = 1'b1;
            end
        end

        // Bytes shifted past the slot end are exactly the truncated ones.
        if (accept) begin
            placed = {keep_bytes(in_data, nb), {(SLOT_W-64){1'b0}}} >> {base, 3'b000};
            over   = (int'(base) + int'(nb)) > MSG_BYTES;
            slot_d[fill_q] = (in_sop ? '0 : slot_q[fill_q]) | placed;
            if (in_eop) begin
                commit    = 1'b1;
                state_d   = IDLE;
                bytepos_d = '0;
                trunc_d   = 1'b0;
                etr_d     = trunc_prev | over;
            end else begin
                state_d   = BODY;
                bytepos_d = (int'(base) + 8 >= MSG_BYTES) ? BP_W'(MSG_BYTES) : base + BP_W'(8);
                trunc_d   = trunc_prev | over;
            end
        end

        count_post = {1'b0, fill_q} + {2'b00, commit};
        flush_req  = in_flush | flush_pend_q;
        counting   = (state_q == IDLE) && (fill_q != 2'd0) && !in_valid;

        if (in_valid)      idle_cnt_d = '0;
        else if (counting) idle_cnt_d = idle_cnt_q + 8'd1;

        if (in_flush && state_d == BODY && (state_q == BODY || fill_q != 2'd0))
            flush_pend_d = 1'b1;

        emit = (count_post == 3'd3)
             || (flush_req && state_d == IDLE && count_post != 3'd0)
             || (counting && idle_cnt_q == 8'(FLUSH_CYCLES - 1));

        if (emit) begin
            for (int k = 0; k < 3; k++) begin
                out_d[k]  = (k < int'(count_post)) ? slot_d[k] : '0;
                slot_d[k] = '0;
            end
            num_d        = count_post[1:0];
            men_d        = 1'b1;
            fill_d       = 2'd0;
            flush_pend_d = 1'b0;
            idle_cnt_d   = '0;
        end else begin
            fill_d = count_post[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            fill_q       <= '0;
            bytepos_q    <= '0;
            idle_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
            trunc_q      <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                slot_q[k] <= '0;
                out_q[k]  <= '0;
            end
            men_q <= 1'b0;
            num_q <= '0;
            etr_q <= 1'b0;
            efr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_q       <= fill_d;
            bytepos_q    <= bytepos_d;
            idle_cnt_q   <= idle_cnt_d;
            flush_pend_q <= flush_pend_d;
            trunc_q      <= trunc_d;
            slot_q       <= slot_d;
            out_q        <= out_d;
            men_q        <= men_d;
            num_q        <= num_d;
            etr_q        <= etr_d;
            efr_q        <= efr_d;
        end
    end

    assign original_data_1    = out_q[0];
    assign original_data_2    = out_q[1];
    assign original_data_3    = out_q[2];
    assign message_en_out     = men_q;
    assign message_number_out = num_q;
    assign err_trunc          = etr_q;
    assign err_frame          = efr_q;
endmodule

// File: doc/opra_msg_block_packer.md
# opra_msg_block_packer

Stage-1 front end of the OPRA encode pipeline. Takes the framed 64-bit message stream from the network/parse layer, left-aligns each message into a 264-bit slot, and groups up to three messages into one block. Each block is presented to the stage-2 encoder on `original_data_1/2/3` with a one-cycle `message_en` pulse. The block contains no backpressure because stage 2 accepts one block per cycle unconditionally.

## Interface
- `MSG_BYTES`, 33: slot size in bytes; slot width = 8*MSG_BYTES = 264 (`MAX_ORIGINAL_DATA_BITS`)
- `FLUSH_CYCLES`, 16: idle cycles before a partial block is emitted; legal range 1..255
- `clk`  in  1  single clock, all logic rising-edge
- `rst_n`  in  1  synchronous, active-low reset
- `in_valid`  in  1  word qualifier
- `in_sop`  in  1  first word of a message (valid with `in_valid`)
- `in_eop`  in  1  last word of a message (valid with `in_valid`); may coincide with `in_sop`
- `in_bytes`  in  3  valid bytes in the eop word, 1..7; 0 means 8; ignored on non-eop words
- `in_data`  in  64  byte 0 = `[63:56]`
- `in_flush`  in  1  request emission of a partial block
- `original_data_1/2/3`  out  264 each  slot contents; message byte j at bits `[263-8j -: 8]`; unused bytes and slots are zero
- `message_en_out`  out  1  one-cycle block-valid pulse
- `message_number_out`  out  2  messages in the current block, 1..3
- `err_trunc`  out  1  one-cycle pulse: message exceeded MSG_BYTES and was truncated
- `err_frame`  out  1  one-cycle pulse: framing violation

## Operation
- FSM states:
  - IDLE: no message in progress.
  - BODY: message in progress.
- Transitions:
  - IDLE with `in_valid & in_sop & !in_eop` → BODY.
  - BODY with `in_valid & in_eop` → IDLE.
  - A single-word message (sop and eop together) stays in IDLE.
- Assembly:
  - Each message is written into working slot `fill` (0..2) at byte offset `bytepos`.
  - `bytepos` resets to 0 on sop and advances by 8 per non-eop word.
  - The slot is cleared to zero on sop before the bytes are written.
- Truncation:
  - Bytes at position ≥ MSG_BYTES are discarded.
  - `bytepos` saturates at MSG_BYTES.
  - `err_trunc` pulses once, on the eop edge of the offending message.
- Commit on eop: `fill` increments. At 3, the block is emitted and `fill` returns to 0.
- Emission:
  - Working slots 1..3 are copied to `original_data_1/2/3`; slots beyond `fill` are forced to zero.
  - `message_number_out` is set to the message count.
  - `message_en_out` is asserted for one cycle.
  - The working slots are cleared.
  - Outputs hold their value between pulses.
- Framing errors (each pulses `err_frame` for one cycle):
  - sop while in BODY: the partial message is discarded, and the new message starts in the same slot.
  - Non-sop word while in IDLE: the word is dropped.
- Flush, `in_flush` sampled high:
  - In IDLE with `fill` ≥ 1: emit on that edge.
  - In BODY: set `flush_pend`; emit on the eop edge, including the completing message.
  - With `fill` = 0 in IDLE: no effect.
- Timeout:
  - `idle_cnt` counts edges with state IDLE, `fill` ≥ 1 and `in_valid` = 0.
  - It resets on any `in_valid` and on emission.
  - When it reaches FLUSH_CYCLES, a partial block is emitted.

## Timing
- Reset (`rst_n` low at an edge): all outputs are zero, and `message_number_out` = 0. State = IDLE, `fill` = 0, `bytepos` = 0, `idle_cnt` = 0, `flush_pend` = 0, working slots zero.
- Reset mid-message or with a partial block: the content is discarded, and no emission occurs.
- Latency: block outputs and `message_en_out` are registered on the same edge that samples the completing eop word (or the flush/timeout condition). They are visible in the following cycle.
- Minimum gap between `message_en_out` pulses: 1 cycle. Three consecutive single-word messages produce a pulse after edge 3; the next block can pulse after edge 6.
- Simultaneous events:
  - eop that fills slot 3 together with `in_flush`: one emission with 3 messages; the flush is consumed.
  - sop arriving on the edge where `idle_cnt` would expire: no timeout, because `in_valid` resets the counter.
  - Error pulses are coincident with the edge that detects them and are independent of `message_en_out`.

## Test plan
- Three single-word messages: bytes `41 4E 4E FF FF FF FF 0F` (`in_bytes` = 0), then `41 4E 53 55…` (`in_bytes` = 0), then `00…` (`in_bytes` = 4). Required: one pulse; `message_number_out` = 3; `original_data_1[263:200]` = 0x414E4EFFFFFFFF0F with the rest zero; `original_data_3` entirely zero.
- Five-word message of 40 bytes: `err_trunc` pulses on the eop edge; the slot holds bytes 0..32; byte 33 onward is not stored.
- One message, then idle with FLUSH_CYCLES = 16: `message_en_out` asserts exactly 16 edges after the eop edge; `message_number_out` = 1; `original_data_2` and `original_data_3` = 0.
- `in_flush` raised mid-message (second message in progress): no pulse until eop; at eop, one pulse with `message_number_out` = 2.
- sop, body, then a second sop without eop: `err_frame` pulses; the first message is absent from the block. Also, a word without sop in IDLE: `err_frame` pulses and the word is dropped.
- Reset asserted after 2 committed messages, then 1 new message followed by flush: the block has `message_number_out` = 1 and contains only the new message.
